sequenciador_cpu: RTL and testbench
===================================

Name: sequenciador_cpu

Overview:
Multi-cycle control FSM for the 4-bit accumulator CPU. It fetches a 3-bit opcode from memoria through a ready handshake and decodes it. It then drives the load/clear codes of registradorX/Y/Z and the ula operation code, and pulses the contador (pc) increment. It replaces the single-cycle controle path so that memory may take a variable number of cycles.

Parameters:
LARG_CTRL, 4, width of tx/ty/tz/tula control codes
TIMEOUT, 15, max cycles waiting for mem_pronta in BUSCA before ERRO (1..255)
PARA_NO_FIM, 1, 1 = halt when pc rco is high at increment; 0 = wrap and continue

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
inicio  input  1  start/resume pulse, sampled in OCIOSO, PARADO, ERRO
instrucao  input  3  opcode from memoria, valid when mem_pronta=1
mem_pronta  input  1  memoria ready/ack for the current fetch
rco  input  1  pc ripple carry out (pc at last address)
mem_le  output  1  fetch request to memoria
pc_inc  output  1  one-cycle pc increment enable
tx  output  LARG_CTRL  registradorX code
ty  output  LARG_CTRL  registradorY code
tz  output  LARG_CTRL  registradorZ code
tula  output  LARG_CTRL  ula operation code
ocupado  output  1  high in BUSCA..INCREMENTA
parado  output  1  high in PARADO
erro  output  1  high in ERRO
instr_exec  output  8  count of retired instructions

Behaviour:
- Register codes: 0=HOLD, 1=LOAD, 2=CLEAR. ula codes: 0=IDLE, 1=ADD (X+Y), 2=SUB (Y-X). All other values are unused.
- Opcodes: 000 NOP; 001 LDX (tx=LOAD); 010 ADD (Y<=X+Y); 011 SUB (Y<=Y-X); 100 MVZ (tz=LOAD, Z<=Y); 101 CLRY (ty=CLEAR); 110 CLRA (tx=ty=tz=CLEAR); 111 HLT.
- Reset (async, reset=0): state OCIOSO. All outputs are 0, the IR is 000, the timeout counter is 0 and instr_exec is 0.
- Outputs are registered/Moore. A code asserted in a state is valid for exactly the cycles the FSM is in that state. Default outside the active state is HOLD/IDLE/0.
- OCIOSO: if inicio=1, go to BUSCA.
- BUSCA:
  - mem_le=1 and the timeout counter increments every cycle.
  - If mem_pronta=1, latch IR<=instrucao, clear the counter and go to DECODIFICA.
  - Otherwise, if the counter equals TIMEOUT-1, go to ERRO.
  - mem_pronta has priority over timeout when both occur in the same cycle.
- DECODIFICA: one cycle, all controls idle. HLT goes to PARADO (no pc_inc, instr_exec unchanged). Every other opcode goes to EXECUTA.
- EXECUTA:
  - ADD/SUB: drive tula only and go to ESCRITA. This gives the ula one settle cycle.
  - LDX/MVZ/CLRY/CLRA: drive their codes for 1 cycle, then go to INCREMENTA.
  - NOP: no codes, go to INCREMENTA.
- ESCRITA: tula held at the same code, ty=LOAD for 1 cycle, then go to INCREMENTA.
- INCREMENTA:
  - pc_inc=1 for exactly 1 cycle and instr_exec+=1 (8-bit, wraps 255->0).
  - If rco=1 and PARA_NO_FIM=1, go to PARADO. Otherwise go to BUSCA.
- PARADO: parado=1. inicio=1 goes to BUSCA; the pc is not reset, so execution resumes at the current address.
- ERRO: erro=1 is sticky. inicio=1 clears it and goes to BUSCA, retrying the same address. Only reset clears instr_exec.
- inicio outside OCIOSO/PARADO/ERRO is ignored.
- Latency:
  - NOP/LDX/MVZ/CLRY/CLRA: 4 cycles from the mem_pronta edge-sample to the next mem_le (DECODIFICA, EXECUTA, INCREMENTA, then BUSCA).
  - ADD/SUB: 5 cycles.
  - With zero-wait memory (mem_pronta already high), a full fetch adds 1 cycle.
- Reset asserted mid-instruction: outputs drop to 0 asynchronously and no partial pc_inc is issued.
- tx/ty/tz are never LOAD and CLEAR on the same register in the same cycle. pc_inc is never high in the same cycle as any register LOAD/CLEAR.

Test Plan:
- Reset, inicio pulse, memory returns 001 with 0 wait -> mem_le 1 cycle; DECODIFICA; tx=1 for 1 cycle; pc_inc 1 cycle; instr_exec=1; back in BUSCA.
- Opcode 010 with mem_pronta after 3 wait cycles -> mem_le high 4 cycles; then tula=1 for 2 cycles with ty=1 only in the 2nd; then pc_inc; ty never overlaps pc_inc.
- mem_pronta held low, TIMEOUT=15 -> erro=1 after 15 cycles of mem_le, no pc_inc. inicio -> BUSCA with erro=0.
- Sequence 110, 100, 111 -> CLRA asserts tx=ty=tz=2 together; MVZ tz=1; HLT gives parado=1 with no pc_inc and instr_exec=2.
- rco=1 during INCREMENTA: PARA_NO_FIM=1 -> PARADO; PARA_NO_FIM=0 -> BUSCA. Run 256 NOPs with PARA_NO_FIM=0 -> instr_exec wraps to 0.
- Assert reset=0 during ESCRITA -> all outputs 0 immediately. Release -> OCIOSO, no fetch until inicio.

Source files
------------

// File: rtl/sequenciador_cpu.sv
// Multi-cycle control sequencer for the 4-bit accumulator CPU: fetches an opcode
// over a ready handshake, then drives register/ula codes and the pc increment.
module sequenciador_cpu #(
  parameter int LARG_CTRL   = 4,
  parameter int TIMEOUT     = 15,
  parameter int PARA_NO_FIM = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [2:0]           instrucao,
  input  logic                 mem_pronta,
  input  logic                 rco,
  output logic                 mem_le,
  output logic                 pc_inc,
  output logic [LARG_CTRL-1:0] tx,
  output logic [LARG_CTRL-1:0] ty,
  output logic [LARG_CTRL-1:0] tz,
  output logic [LARG_CTRL-1:0] tula,
  output logic                 ocupado,
  output logic                 parado,
  output logic                 erro,
  output logic [7:0]           instr_exec
);

  localparam logic [2:0] S_OCIOSO     = 3'd0;
  localparam logic [2:0] S_BUSCA      = 3'd1;
  localparam logic [2:0] S_DECODIFICA = 3'd2;
  localparam logic [2:0] S_EXECUTA    = 3'd3;
  localparam logic [2:0] S_ESCRITA    = 3'd4;
  localparam logic [2:0] S_INCREMENTA = 3'd5;
  localparam logic [2:0] S_PARADO     = 3'd6;
  localparam logic [2:0] S_ERRO       = 3'd7;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDX  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVZ  = 3'b100;
  localparam logic [2:0] OP_CLRY = 3'b101;
  localparam logic [2:0] OP_CLRA = 3'b110;
  localparam logic [2:0] OP_HLT  = 3'b111;

  localparam logic [LARG_CTRL-1:0] R_LOAD  = LARG_CTRL'(1);
  localparam logic [LARG_CTRL-1:0] R_CLEAR = LARG_CTRL'(2);
  localparam logic [LARG_CTRL-1:0] U_ADD   = LARG_CTRL'(1);
  localparam logic [LARG_CTRL-1:0] U_SUB   = LARG_CTRL'(2);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [2:0]           ir_q, ir_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           exec_q, exec_d;
  logic                 mem_le_q, mem_le_d;
  logic                 pc_inc_q, pc_inc_d;
  logic [LARG_CTRL-1:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d, tula_q, tula_d;
  logic                 ocupado_q, ocupado_d;
  logic                 parado_q, parado_d;
  logic                 erro_q, erro_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    exec_d  = exec_q;
    case (state_q)
      S_OCIOSO: if (inicio) state_d = S_BUSCA;
      S_BUSCA: begin
        cnt_d = cnt_q + 8'd1;
        // a ready fetch wins over a timeout landing on the same cycle
        if (mem_pronta) begin
          ir_d    = instrucao;
          cnt_d   = '0;
          state_d = S_DECODIFICA;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = S_ERRO;
        end
      end
      S_DECODIFICA: state_d = (ir_q == OP_HLT) ? S_PARADO : S_EXECUTA;
      S_EXECUTA:    state_d = (ir_q == OP_ADD || ir_q == OP_SUB) ? S_ESCRITA : S_INCREMENTA;
      S_ESCRITA:    state_d = S_INCREMENTA;
      S_INCREMENTA: begin
        exec_d  = exec_q + 8'd1;
        state_d = (rco && (PARA_NO_FIM != 0)) ? S_PARADO : S_BUSCA;
      end
      S_PARADO, S_ERRO: if (inicio) state_d = S_BUSCA;
      default: state_d = S_OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet Moore-aligned.
  always_comb begin
    mem_le_d  = 1'b0;
    pc_inc_d  = 1'b0;
    tx_d      = '0;
    ty_d      = '0;
    tz_d      = '0;
    tula_d    = '0;
    ocupado_d = 1'b0;
    parado_d  = 1'b0;
    erro_d    = 1'b0;
    case (state_d)
      S_BUSCA: begin
        mem_le_d  = 1'b1;
        ocupado_d = 1'b1;
      end
      S_DECODIFICA: ocupado_d = 1'b1;
      S_EXECUTA: begin
        ocupado_d = 1'b1;
        case (ir_d)
          OP_LDX:  tx_d   = R_LOAD;
          OP_ADD:  tula_d = U_ADD;
          OP_SUB:  tula_d = U_SUB;
          OP_MVZ:  tz_d   = R_LOAD;
          OP_CLRY: ty_d   = R_CLEAR;
          OP_CLRA: begin
            tx_d = R_CLEAR;
            ty_d = R_CLEAR;
            tz_d = R_CLEAR;
          end
          OP_NOP, OP_HLT: ;
          default: ;
        endcase
      end
      S_ESCRITA: begin
        ocupado_d = 1'b1;
        ty_d      = R_LOAD;
        tula_d    = (ir_d == OP_SUB) ? U_SUB : U_ADD;
      end
      S_INCREMENTA: begin
        ocupado_d = 1'b1;
        pc_inc_d  = 1'b1;
      end
      S_PARADO: parado_d = 1'b1;
      S_ERRO:   erro_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OCIOSO;
      ir_q      <= '0;
      cnt_q     <= '0;
      exec_q    <= '0;
      mem_le_q  <= 1'b0;
      pc_inc_q  <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
      tz_q      <= '0;
      tula_q    <= '0;
      ocupado_q <= 1'b0;
      parado_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      exec_q    <= exec_d;
      mem_le_q  <= mem_le_d;
      pc_inc_q  <= pc_inc_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      tz_q      <= tz_d;
      tula_q    <= tula_d;
      ocupado_q <= ocupado_d;
      parado_q  <= parado_d;
      erro_q    <= erro_d;
    end
  end

  assign mem_le     = mem_le_q;
  assign pc_inc     = pc_inc_q;
  assign tx         = tx_q;
  assign ty         = ty_q;
  assign tz         = tz_q;
  assign tula       = tula_q;
  assign ocupado    = ocupado_q;
  assign parado     = parado_q;
  assign erro       = erro_q;
  assign instr_exec = exec_q;

endmodule

// File: tb/tb_sequenciador_cpu.sv
// Bench for sequenciador_cpu: per-opcode expected traces built from a table and
// compared cycle by cycle against two instances (halt-at-end and wrap-around).
module tb_sequenciador_cpu;

  localparam int TIMEOUT = 15;
  localparam logic [3:0] HOLD = 4'd0, LOAD = 4'd1, CLR = 4'd2;
  localparam logic [3:0] UADD = 4'd1, USUB = 4'd2;

  typedef struct {
    logic [2:0] op;
    logic [3:0] tx, ty, tz, tula;
    bit         two;
    bit         halt;
  } vec_t;

  vec_t tab[8];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inicio = 1'b0;
  logic [2:0] instrucao = 3'd0;
  logic       mem_pronta = 1'b0;
  logic       rco = 1'b0;

  logic       a_le, a_pi, a_oc, a_pa, a_er;
  logic [3:0] a_tx, a_ty, a_tz, a_tu;
  logic [7:0] a_ex;
  logic       b_le, b_pi, b_oc, b_pa, b_er;
  logic [3:0] b_tx, b_ty, b_tz, b_tu;
  logic [7:0] b_ex;

  int         vectors = 0;
  int         miscompares = 0;
  int         sel = 0;
  logic [7:0] exp_cnt = 8'd0;

  sequenciador_cpu #(.LARG_CTRL(4), .TIMEOUT(TIMEOUT), .PARA_NO_FIM(1)) u_dut (
    .clock(clock), .reset(reset), .inicio(inicio), .instrucao(instrucao),
    .mem_pronta(mem_pronta), .rco(rco), .mem_le(a_le), .pc_inc(a_pi),
    .tx(a_tx), .ty(a_ty), .tz(a_tz), .tula(a_tu), .ocupado(a_oc),
    .parado(a_pa), .erro(a_er), .instr_exec(a_ex));

  sequenciador_cpu #(.LARG_CTRL(4), .TIMEOUT(TIMEOUT), .PARA_NO_FIM(0)) u_wrap (
    .clock(clock), .reset(reset), .inicio(inicio), .instrucao(instrucao),
    .mem_pronta(mem_pronta), .rco(rco), .mem_le(b_le), .pc_inc(b_pi),
    .tx(b_tx), .ty(b_ty), .tz(b_tz), .tula(b_tu), .ocupado(b_oc),
    .parado(b_pa), .erro(b_er), .instr_exec(b_ex));

  always #5 clock = ~clock;

  function automatic logic [20:0] mk(input logic le, input logic pi, input logic [3:0] x,
                                     input logic [3:0] y, input logic [3:0] z,
                                     input logic [3:0] u, input logic oc,
                                     input logic pa, input logic er);
    return {le, pi, x, y, z, u, oc, pa, er};
  endfunction

  function automatic logic [28:0] act();
    if (sel != 0) return {b_le, b_pi, b_tx, b_ty, b_tz, b_tu, b_oc, b_pa, b_er, b_ex};
    return {a_le, a_pi, a_tx, a_ty, a_tz, a_tu, a_oc, a_pa, a_er, a_ex};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [20:0] r);
    logic [28:0] a, e;
    a = act();
    e = {r, exp_cnt};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got {le,pi,tx,ty,tz,tula,oc,pa,er,cnt}=%h expected %h", nm, a, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    exp_cnt = 8'd0;
    check("reset_async", '0);
    step();
    step();
    reset = 1'b1;
    step();
    check("idle_no_inicio_0", '0);
    step();
    check("idle_no_inicio_1", '0);
  endtask

  task automatic start();
    inicio = 1'b1;
    step();
    inicio = 1'b0;
  endtask

  // Builds the expected per-cycle trace of one fetch+execute, starting in BUSCA.
  // land: 0 = next cycle back in BUSCA, 1 = PARADO, 2 = ERRO.
  task automatic run_instr(input logic [2:0] op, input int w, input logic r, output int land);
    logic [20:0] q[$];
    vec_t        v;
    int          nb;
    v  = tab[op];
    nb = (w < TIMEOUT) ? w + 1 : TIMEOUT;
    for (int k = 0; k < nb; k++) q.push_back(mk(1'b1, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));
    if (w >= TIMEOUT) begin
      land = 2;
    end else begin
      q.push_back(mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));
      if (v.halt) begin
        land = 1;
      end else begin
        q.push_back(mk(1'b0, 1'b0, v.tx, v.ty, v.tz, v.tula, 1'b1, 1'b0, 1'b0));
        if (v.two) q.push_back(mk(1'b0, 1'b0, HOLD, LOAD, HOLD, v.tula, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b1, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));
        land = (r && sel == 0) ? 1 : 0;
      end
    end
    foreach (q[k]) begin
      check($sformatf("op%0d_w%0d_cyc%0d", op, w, k), q[k]);
      instrucao  = op;
      rco        = r;
      mem_pronta = (k == w);
      inicio     = 1'($urandom_range(0, 1));
      step();
      if (q[k][19]) exp_cnt = exp_cnt + 8'd1;
    end
    mem_pronta = 1'b0;
    rco        = 1'b0;
    inicio     = 1'b0;
  endtask

  task automatic settle(input int land);
    if (land == 1) check("parado", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b1, 1'b0));
    if (land == 2) check("erro", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b0, 1'b1));
    if (land != 0) begin
      step();
      if (land == 1) check("parado_hold", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b1, 1'b0));
      else           check("erro_sticky", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b0, 1'b1));
      start();
    end
  endtask

  initial begin
    int         land;
    int         w;
    logic [2:0] op;
    logic       r;

    tab[0] = '{3'b000, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b0};
    tab[1] = '{3'b001, LOAD, HOLD, HOLD, HOLD, 1'b0, 1'b0};
    tab[2] = '{3'b010, HOLD, HOLD, HOLD, UADD, 1'b1, 1'b0};
    tab[3] = '{3'b011, HOLD, HOLD, HOLD, USUB, 1'b1, 1'b0};
    tab[4] = '{3'b100, HOLD, HOLD, LOAD, HOLD, 1'b0, 1'b0};
    tab[5] = '{3'b101, HOLD, CLR,  HOLD, HOLD, 1'b0, 1'b0};
    tab[6] = '{3'b110, CLR,  CLR,  CLR,  HOLD, 1'b0, 1'b0};
    tab[7] = '{3'b111, HOLD, HOLD, HOLD, HOLD, 1'b0, 1'b1};

    #1;
    sel = 0;
    do_reset();
    start();

    run_instr(3'b001, 0, 1'b0, land);  settle(land);
    run_instr(3'b010, 3, 1'b0, land);  settle(land);
    run_instr(3'b011, 20, 1'b0, land); settle(land);
    run_instr(3'b000, TIMEOUT - 1, 1'b0, land); settle(land);
    run_instr(3'b000, TIMEOUT, 1'b0, land);     settle(land);

    for (int i = 0; i < 8; i++) begin
      run_instr(tab[i].op, int'($urandom_range(0, 3)), 1'b0, land);
      settle(land);
    end

    run_instr(3'b000, 1, 1'b1, land); settle(land);

    do_reset();
    start();
    run_instr(3'b110, 0, 1'b0, land); settle(land);
    run_instr(3'b100, 2, 1'b0, land); settle(land);
    run_instr(3'b111, 1, 1'b0, land); settle(land);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3))
                                       : int'($urandom_range(0, 5));
      r  = ($urandom_range(0, 7) == 0);
      run_instr(op, w, r, land);
      settle(land);
    end

    // reset pulled while the write-back cycle of an ADD is active
    instrucao  = 3'b010;
    mem_pronta = 1'b1;
    check("esc_busca", mk(1'b1, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));
    step();
    mem_pronta = 1'b0;
    check("esc_decod", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));
    step();
    check("esc_exec", mk(1'b0, 1'b0, HOLD, HOLD, HOLD, UADD, 1'b1, 1'b0, 1'b0));
    step();
    check("esc_escrita", mk(1'b0, 1'b0, HOLD, LOAD, HOLD, UADD, 1'b1, 1'b0, 1'b0));
    #2;
    do_reset();

    sel = 1;
    do_reset();
    start();
    for (int i = 0; i < 256; i++) begin
      run_instr(3'b000, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), land);
      settle(land);
    end
    check("wrap_cnt_zero", mk(1'b1, 1'b0, HOLD, HOLD, HOLD, HOLD, 1'b1, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
